// File: rtl/inst_data_arbiter.sv
// inst_data_arbiter
// Shares one SRAM-like bus between the IF-stage fetch port and the MEM-stage
// data port. One transaction is in flight at a time; data wins ties because
// it is older in program order. A fetch that is flushed before its address
// phase is accepted is withdrawn; one flushed after acceptance completes on
// the bus, but its result is dropped.
module inst_data_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,
    input  logic        flush,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        owner_r;        // 1'b0 = fetch, 1'b1 = data
    logic        discard_r;
    logic [31:0] rdata_q_r;
    logic        bus_req_r;
    logic        bus_wr_r;
    logic [3:0]  bus_wstrb_r;
    logic [31:0] bus_addr_r;
    logic [31:0] bus_wdata_r;
    logic        inst_ok_r;
    logic        data_ok_r;
    logic [31:0] inst_rdata_r;
    logic [31:0] data_rdata_r;

    logic        owner_nxt_s;
    logic        discard_nxt_s;
    logic [31:0] rdata_q_nxt_s;
    logic        bus_req_nxt_s;
    logic        bus_wr_nxt_s;
    logic [3:0]  bus_wstrb_nxt_s;
    logic [31:0] bus_addr_nxt_s;
    logic [31:0] bus_wdata_nxt_s;
    logic        inst_ok_nxt_s;
    logic        data_ok_nxt_s;
    logic [31:0] inst_rdata_nxt_s;
    logic [31:0] data_rdata_nxt_s;

    logic        grant_data_s;
    logic        grant_inst_s;
    logic        inst_flush_s;
    logic        inst_cancel_s;

    // A fetch is never granted in the same cycle that a flush kills it.
    assign grant_data_s  = data_req;
    assign grant_inst_s  = ~data_req & inst_req & ~flush;
    // Flush only ever concerns a transaction owned by the fetch port.
    assign inst_flush_s  = ~owner_r & flush;
    // Withdrawal is only safe while the slave has not taken the address.
    assign inst_cancel_s = inst_flush_s & ~bus_addr_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode for the bus transaction sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_data_s | grant_inst_s) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (inst_cancel_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus_addr_ok) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DONE: begin
                // Requesters still hold req during their ok cycle; never sample here.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the latched request, discard flag and registered outputs.
    always_comb begin
        owner_nxt_s      = owner_r;
        discard_nxt_s    = discard_r;
        rdata_q_nxt_s    = rdata_q_r;
        bus_wr_nxt_s     = bus_wr_r;
        bus_wstrb_nxt_s  = bus_wstrb_r;
        bus_addr_nxt_s   = bus_addr_r;
        bus_wdata_nxt_s  = bus_wdata_r;
        inst_ok_nxt_s    = 1'b0;
        data_ok_nxt_s    = 1'b0;
        inst_rdata_nxt_s = 32'h0000_0000;
        data_rdata_nxt_s = 32'h0000_0000;
        // bus_req is high exactly while the next state is the address phase.
        bus_req_nxt_s    = (state_nxt_s == ST_ADDR);
        case (state_r)
            ST_IDLE: begin
                discard_nxt_s = 1'b0;
                if (grant_data_s) begin
                    owner_nxt_s     = 1'b1;
                    bus_addr_nxt_s  = data_addr;
                    bus_wdata_nxt_s = data_wdata;
                    bus_wstrb_nxt_s = data_wen;
                    bus_wr_nxt_s    = |data_wen;
                end else if (grant_inst_s) begin
                    owner_nxt_s     = 1'b0;
                    bus_addr_nxt_s  = inst_addr;
                    bus_wdata_nxt_s = 32'h0000_0000;
                    bus_wstrb_nxt_s = 4'b0000;
                    bus_wr_nxt_s    = 1'b0;
                end else begin
                    owner_nxt_s     = owner_r;
                end
            end
            ST_ADDR: begin
                // Address already accepted: the data phase must still be drained.
                if (inst_flush_s & bus_addr_ok) begin
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_r;
                end
            end
            ST_DATA: begin
                discard_nxt_s = discard_r | inst_flush_s;
                if (bus_data_ok) begin
                    rdata_q_nxt_s = bus_rdata;
                    if (owner_r) begin
                        data_ok_nxt_s    = 1'b1;
                        data_rdata_nxt_s = bus_rdata;
                    end else if (~discard_nxt_s) begin
                        inst_ok_nxt_s    = 1'b1;
                        inst_rdata_nxt_s = bus_rdata;
                    end else begin
                        inst_ok_nxt_s    = 1'b0;
                    end
                end else begin
                    rdata_q_nxt_s = rdata_q_r;
                end
            end
            ST_DONE: begin
                discard_nxt_s = 1'b0;
            end
            default: begin
                discard_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= 1'b0;
            discard_r    <= 1'b0;
            rdata_q_r    <= 32'h0000_0000;
            bus_req_r    <= 1'b0;
            bus_wr_r     <= 1'b0;
            bus_wstrb_r  <= 4'b0000;
            bus_addr_r   <= 32'h0000_0000;
            bus_wdata_r  <= 32'h0000_0000;
            inst_ok_r    <= 1'b0;
            data_ok_r    <= 1'b0;
            inst_rdata_r <= 32'h0000_0000;
            data_rdata_r <= 32'h0000_0000;
        end else begin
            owner_r      <= owner_nxt_s;
            discard_r    <= discard_nxt_s;
            rdata_q_r    <= rdata_q_nxt_s;
            bus_req_r    <= bus_req_nxt_s;
            bus_wr_r     <= bus_wr_nxt_s;
            bus_wstrb_r  <= bus_wstrb_nxt_s;
            bus_addr_r   <= bus_addr_nxt_s;
            bus_wdata_r  <= bus_wdata_nxt_s;
            inst_ok_r    <= inst_ok_nxt_s;
            data_ok_r    <= data_ok_nxt_s;
            inst_rdata_r <= inst_rdata_nxt_s;
            data_rdata_r <= data_rdata_nxt_s;
        end
    end

    assign bus_req    = bus_req_r;
    assign bus_wr     = bus_wr_r;
    assign bus_wstrb  = bus_wstrb_r;
    assign bus_addr   = bus_addr_r;
    assign bus_wdata  = bus_wdata_r;
    assign inst_ok    = inst_ok_r;
    assign data_ok    = data_ok_r;
    assign inst_rdata = inst_rdata_r;
    assign data_rdata = data_rdata_r;

    // Stalls drop in the same cycle as the matching ok pulse.
    assign stall_if   = inst_req & ~inst_ok_r;
    assign stall_mem  = data_req & ~data_ok_r;

endmodule

// File: tb/tb_inst_data_arbiter.sv
// Directed bench for inst_data_arbiter with a completion scoreboard.
module tb_inst_data_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        flush;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    inst_data_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ok    (inst_ok),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ok    (data_ok),
        .flush      (flush),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_wstrb  (bus_wstrb),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata)
    );

    // 10 ns pipeline clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard whenever the DUT signals a completion.
    task automatic sb_monitor();
        exp_t e;
        if (inst_ok === 1'b1) begin
            chk("sb_inst_pending", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_inst_port", 32'(inst_ok & ~e.is_data), 32'd1);
                chk("sb_inst_rdata", inst_rdata, e.rdata);
            end
        end
        if (data_ok === 1'b1) begin
            chk("sb_data_pending", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_data_port", 32'(data_ok & e.is_data), 32'd1);
                chk("sb_data_rdata", data_rdata, e.rdata);
            end
        end
    endtask

    // Sample point in the middle of the current cycle.
    task automatic half();
        @(negedge clk);
        sb_monitor();
    endtask

    // Advance to just after the next rising edge, ready to drive inputs.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        half();
        nxt();
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0;
        data_wen = 4'b0000; data_addr = 32'h0; data_wdata = 32'h0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        nxt(); nxt();
        // ---- reset state
        half();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_inst_ok", 32'(inst_ok), 32'd0);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        nxt();
        rst = 1'b0;
        nxt();

        // ---- single fetch at minimum latency
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        sbq.push_back('{1'b0, 32'h3C08_0001});
        half(); chk("f_c0_stall_if", 32'(stall_if), 32'd1); chk("f_c0_bus_req", 32'(bus_req), 32'd0); nxt();
        bus_addr_ok = 1'b1;
        half(); chk("f_c1_bus_req", 32'(bus_req), 32'd1); chk("f_c1_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("f_c1_bus_wr", 32'(bus_wr), 32'd0); chk("f_c1_stall_if", 32'(stall_if), 32'd1); nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C08_0001;
        half(); chk("f_c2_bus_req", 32'(bus_req), 32'd0); chk("f_c2_inst_ok", 32'(inst_ok), 32'd0);
        chk("f_c2_stall_if", 32'(stall_if), 32'd1); nxt();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        half(); chk("f_c3_inst_ok", 32'(inst_ok), 32'd1); chk("f_c3_stall_if", 32'(stall_if), 32'd0); nxt();
        inst_req = 1'b0;
        half(); chk("f_c4_inst_ok", 32'(inst_ok), 32'd0); chk("f_c4_inst_rdata", inst_rdata, 32'h0); nxt();

        // ---- simultaneous load and fetch: data first
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0010;
        sbq.push_back('{1'b1, 32'h1234_5678});
        sbq.push_back('{1'b0, 32'h2402_0002});
        half(); chk("s_c0_stall_mem", 32'(stall_mem), 32'd1); chk("s_c0_stall_if", 32'(stall_if), 32'd1); nxt();
        bus_addr_ok = 1'b1;
        half(); chk("s_c1_bus_req", 32'(bus_req), 32'd1); chk("s_c1_bus_addr", bus_addr, 32'h8000_0010);
        chk("s_c1_bus_wr", 32'(bus_wr), 32'd0); nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        cyc();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        half(); chk("s_c3_data_ok", 32'(data_ok), 32'd1); chk("s_c3_stall_mem", 32'(stall_mem), 32'd0);
        chk("s_c3_inst_ok", 32'(inst_ok), 32'd0); nxt();
        data_req = 1'b0;
        half(); chk("s_c4_bus_req", 32'(bus_req), 32'd0); nxt();
        bus_addr_ok = 1'b1;
        half(); chk("s_c5_bus_req", 32'(bus_req), 32'd1); chk("s_c5_bus_addr", bus_addr, 32'hBFC0_0004); nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2402_0002;
        half(); chk("s_c6_inst_ok", 32'(inst_ok), 32'd0); nxt();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        half(); chk("s_c7_inst_ok", 32'(inst_ok), 32'd1); nxt();
        inst_req = 1'b0;
        cyc();

        // ---- store with address phase delayed two cycles
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_0020; data_wdata = 32'h0000_BEEF;
        sbq.push_back('{1'b1, 32'h0000_0000});
        cyc();
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) bus_addr_ok = 1'b1;
            half();
            chk("w_bus_req", 32'(bus_req), 32'd1);
            chk("w_bus_wr", 32'(bus_wr), 32'd1);
            chk("w_bus_wstrb", 32'(bus_wstrb), 32'h3);
            chk("w_bus_wdata", bus_wdata, 32'h0000_BEEF);
            chk("w_bus_addr", bus_addr, 32'h8000_0020);
            chk("w_data_ok_early", 32'(data_ok), 32'd0);
            nxt();
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0;
        half(); chk("w_c4_bus_req", 32'(bus_req), 32'd0); chk("w_c4_data_ok", 32'(data_ok), 32'd0); nxt();
        bus_data_ok = 1'b0;
        half(); chk("w_c5_data_ok", 32'(data_ok), 32'd1); nxt();
        data_req = 1'b0; data_wen = 4'b0000;
        half(); chk("w_c6_data_ok", 32'(data_ok), 32'd0); nxt();

        // ---- flush during address phase: withdraw
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        cyc();
        flush = 1'b1;
        half(); chk("fa_c1_bus_req", 32'(bus_req), 32'd1); nxt();
        flush = 1'b0; inst_req = 1'b0;
        half(); chk("fa_c2_bus_req", 32'(bus_req), 32'd0); chk("fa_c2_inst_ok", 32'(inst_ok), 32'd0); nxt();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
        sbq.push_back('{1'b0, 32'hAAAA_5555});
        half(); chk("fa_c3_bus_req", 32'(bus_req), 32'd0); nxt();
        bus_addr_ok = 1'b1;
        half(); chk("fa_c4_bus_req", 32'(bus_req), 32'd1); chk("fa_c4_bus_addr", bus_addr, 32'hBFC0_0010); nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_5555;
        cyc();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        half(); chk("fa_c6_inst_ok", 32'(inst_ok), 32'd1); nxt();
        inst_req = 1'b0;
        cyc();

        // ---- flush during data phase: result discarded, then normal refetch
        inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
        cyc();
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0; flush = 1'b1;
        half(); chk("fd_c2_bus_req", 32'(bus_req), 32'd0); nxt();
        flush = 1'b0; inst_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        cyc();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        half(); chk("fd_c4_inst_ok", 32'(inst_ok), 32'd0); chk("fd_c4_inst_rdata", inst_rdata, 32'h0); nxt();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0380;
        sbq.push_back('{1'b0, 32'h4080_6000});
        half(); chk("fd_c5_bus_req", 32'(bus_req), 32'd0); nxt();
        bus_addr_ok = 1'b1;
        half(); chk("fd_c6_bus_req", 32'(bus_req), 32'd1); chk("fd_c6_bus_addr", bus_addr, 32'hBFC0_0380); nxt();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h4080_6000;
        cyc();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        half(); chk("fd_c8_inst_ok", 32'(inst_ok), 32'd1); nxt();
        inst_req = 1'b0;
        cyc();

        // ---- reset during data phase: abandoned, late data_ok ignored
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0040;
        cyc();
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; data_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        half(); chk("r_c3_bus_req", 32'(bus_req), 32'd0); chk("r_c3_bus_addr", bus_addr, 32'h0);
        chk("r_c3_data_ok", 32'(data_ok), 32'd0); chk("r_c3_data_rdata", data_rdata, 32'h0); nxt();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("r_late_data_ok", 32'(data_ok), 32'd0);
            chk("r_late_inst_ok", 32'(inst_ok), 32'd0);
            chk("r_late_bus_req", 32'(bus_req), 32'd0);
            nxt();
        end

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
